// File: rtl/mem_helper_pkg.sv
// -----------------------------------------------------------------------------
// mem_helper_pkg
// Shared types and helpers for the multi-port simulation memory helper.
//   index_t     : 64-bit entry index carried on every read/write port
//   word_t      : widest supported data word (DATA_W <= MAX_W); instances
//                 size-cast to and from it
//   MEM_POISON  : 'hDEAD... repeated; instances take the top DATA_W bits so
//                 the returned value always starts with 'hDEAD
//   merge_wr    : per-bit masked update of a stored word
// -----------------------------------------------------------------------------
package mem_helper_pkg;

  typedef logic [63:0] index_t;

  localparam int MAX_W = 1024;
  typedef logic [MAX_W-1:0] word_t;

  localparam word_t MEM_POISON = {(MAX_W/16){16'hDEAD}};

  // Bits with mask=1 take data, all others keep the stored value.
  function automatic word_t merge_wr(input word_t old_w, input word_t data, input word_t mask);
    return (old_w & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// mem_rd_pipe
// Read-result delay line for one read port. RD_LAT stages of valid/data;
// a data stage only loads when a valid result moves into it, so out_data
// holds its last value while out_valid is low. RD_LAT=0 is a pass-through.
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-low clear (valid and data to 0)
//   in_valid  : read accepted this cycle
//   in_data   : array data sampled at the accepting edge
//   out_valid : in_valid delayed by RD_LAT cycles
//   out_data  : matching data, held when out_valid is low
// -----------------------------------------------------------------------------
module mem_rd_pipe #(
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  if (RD_LAT == 0) begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;
    assign out_valid      = in_valid;
    assign out_data       = in_data;
  end else begin : g_pipe
    logic [RD_LAT-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [RD_LAT];

    // NOTE: sequential state is updated with <= so every stage samples the
    // pre-edge value of the stage before it.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        vld_q <= '0;
        for (int k = 0; k < RD_LAT; k++) dat_q[k] <= '0;
      end else begin
        vld_q[0] <= in_valid;
        if (in_valid) dat_q[0] <= in_data;
        for (int k = 1; k < RD_LAT; k++) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
        end
      end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_data  = dat_q[RD_LAT-1];
  end

endmodule

// File: rtl/mem_nrnw_helper.sv
// -----------------------------------------------------------------------------
// mem_nrnw_helper
// NR-read / NW-write memory with per-bit write masks, configurable read
// latency, out-of-range detection and access counters.
// Ports:
//   clock, reset          : rising-edge clock, async active-low reset
//   r_enable/r_index      : per read port request and 64-bit index
//   r_data/r_valid        : per read port result, RD_LAT cycles after request
//   r_async               : 1 when RD_LAT==0 (combinational read)
//   w_enable/w_index      : per write port request and 64-bit index
//   w_data/w_mask         : write data and per-bit write enable
//   err_oob               : sticky, any enabled access with index >= DEPTH
//   err_uninit            : (MEM_UNINIT_TRAP_EN only) sticky, read of an
//                           entry never written with a nonzero mask
//   rd_count/wr_count     : enabled reads/writes accepted, modulo 2^32
// Same-index writes in one cycle merge bit by bit; where masks overlap the
// highest-numbered port wins. Reads see the array before the current edge.
// Optional feature macro: MEM_UNINIT_TRAP_EN (written-flag array + poison).
// -----------------------------------------------------------------------------
module mem_nrnw_helper
  import mem_helper_pkg::*;
#(
  parameter int NR     = 2,
  parameter int NW     = 2,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NR-1:0]        r_enable,
  input  logic [NR*64-1:0]     r_index,
  output logic [NR*DATA_W-1:0] r_data,
  output logic [NR-1:0]        r_valid,
  output logic                 r_async,
  input  logic [NW-1:0]        w_enable,
  input  logic [NW*64-1:0]     w_index,
  input  logic [NW*DATA_W-1:0] w_data,
  input  logic [NW*DATA_W-1:0] w_mask,
  output logic                 err_oob,
`ifdef MEM_UNINIT_TRAP_EN
  output logic                 err_uninit,
`endif
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count
);

  localparam int     AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam index_t DEPTH_IDX = index_t'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NR-1:0]     r_ok;
  logic [AW-1:0]     r_addr [NR];
  logic [DATA_W-1:0] rd_raw [NR];
  logic [NW-1:0]     w_ok;
  logic [AW-1:0]     w_addr [NW];
  index_t            w_idx  [NW];
  logic [DATA_W-1:0] w_dat  [NW];
  logic [DATA_W-1:0] w_msk  [NW];
  logic [DATA_W-1:0] w_word [NW];

`ifdef MEM_UNINIT_TRAP_EN
  localparam logic [DATA_W-1:0] POISON = MEM_POISON[MAX_W-1 -: DATA_W];
  logic [DEPTH-1:0] written;
  logic [NR-1:0]    rd_uninit;
`endif

  // Read side: out-of-range reads return zero, never touching the array.
  always_comb begin
`ifdef MEM_UNINIT_TRAP_EN
    rd_uninit = '0;
`endif
    for (int i = 0; i < NR; i++) begin
      r_ok[i]   = r_index[i*64 +: 64] < DEPTH_IDX;
      r_addr[i] = r_index[i*64 +: AW];
      rd_raw[i] = '0;
      if (r_ok[i]) begin
`ifdef MEM_UNINIT_TRAP_EN
        if (!written[r_addr[i]]) begin
          rd_raw[i]    = POISON;
          rd_uninit[i] = r_enable[i];
        end else begin
          rd_raw[i] = mem[r_addr[i]];
        end
`else
        rd_raw[i] = mem[r_addr[i]];
`endif
      end
    end
  end

  // Write side: every port targeting an index folds in all enabled ports on
  // that same index in ascending order, so all of them produce the same word
  // and the highest port's bits land last.
  always_comb begin
    for (int j = 0; j < NW; j++) begin
      w_idx[j]  = w_index[j*64 +: 64];
      w_ok[j]   = w_idx[j] < DEPTH_IDX;
      w_addr[j] = w_index[j*64 +: AW];
      w_dat[j]  = w_data[j*DATA_W +: DATA_W];
      w_msk[j]  = w_mask[j*DATA_W +: DATA_W];
    end
    for (int j = 0; j < NW; j++) begin
      w_word[j] = w_ok[j] ? mem[w_addr[j]] : '0;
      for (int k = 0; k < NW; k++) begin
        if (w_enable[k] && w_ok[k] && (w_idx[k] == w_idx[j]))
          w_word[j] = DATA_W'(merge_wr(word_t'(w_word[j]), word_t'(w_dat[k]),
                                       word_t'(w_msk[k])));
      end
    end
  end

  // NOTE: the array has no reset; its contents are undefined until written,
  // which keeps it mappable onto plain RAM.
  always_ff @(posedge clock) begin
    for (int j = 0; j < NW; j++)
      if (w_enable[j] && w_ok[j]) mem[w_addr[j]] <= w_word[j];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_oob  <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (|(r_enable & ~r_ok) || |(w_enable & ~w_ok)) err_oob <= 1'b1;
      rd_count <= rd_count + 32'($countones(r_enable));
      wr_count <= wr_count + 32'($countones(w_enable));
    end
  end

`ifdef MEM_UNINIT_TRAP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      written    <= '0;
      err_uninit <= 1'b0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (w_enable[j] && w_ok[j] && (|w_msk[j])) written[w_addr[j]] <= 1'b1;
      if (|rd_uninit) err_uninit <= 1'b1;
    end
  end
`endif

  for (genvar i = 0; i < NR; i++) begin : g_rd
    mem_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
    ) u_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (r_enable[i]),
      .in_data   (rd_raw[i]),
      .out_valid (r_valid[i]),
      .out_data  (r_data[i*DATA_W +: DATA_W])
    );
  end

  assign r_async = (RD_LAT == 0);

endmodule

// File: tb/tb_mem_nrnw_helper.sv
// -----------------------------------------------------------------------------
// tb_mem_nrnw_helper
// Four instances (RD_LAT = 0..3, NR=NW=2, DATA_W=16, DEPTH=64) share one
// set of inputs; each scenario checks the instance whose latency it targets.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mem_nrnw_helper;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [1:0]   r_enable;
  logic [127:0] r_index;
  logic [1:0]   w_enable;
  logic [127:0] w_index;
  logic [31:0]  w_data;
  logic [31:0]  w_mask;

  logic [31:0]  r_data_o   [4];
  logic [1:0]   r_valid_o  [4];
  logic         r_async_o  [4];
  logic         err_oob_o  [4];
  logic [31:0]  rd_count_o [4];
  logic [31:0]  wr_count_o [4];
`ifdef MEM_UNINIT_TRAP_EN
  logic         err_uninit_o [4];
`endif

  int checks   = 0;
  int failures = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_nrnw_helper #(
      .NR(2), .NW(2), .DATA_W(16), .DEPTH(64), .RD_LAT(g)
    ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .r_enable   (r_enable),
      .r_index    (r_index),
      .r_data     (r_data_o[g]),
      .r_valid    (r_valid_o[g]),
      .r_async    (r_async_o[g]),
      .w_enable   (w_enable),
      .w_index    (w_index),
      .w_data     (w_data),
      .w_mask     (w_mask),
      .err_oob    (err_oob_o[g]),
`ifdef MEM_UNINIT_TRAP_EN
      .err_uninit (err_uninit_o[g]),
`endif
      .rd_count   (rd_count_o[g]),
      .wr_count   (wr_count_o[g])
    );
  end

  task automatic idle();
    r_enable = '0; r_index = '0;
    w_enable = '0; w_index = '0; w_data = '0; w_mask = '0;
  endtask

  task automatic set_rd(input int p, input int idx);
    r_enable[p]         = 1'b1;
    r_index[p*64 +: 64] = 64'(idx);
  endtask

  task automatic set_wr(input int p, input int idx, input logic [15:0] d, input logic [15:0] m);
    w_enable[p]         = 1'b1;
    w_index[p*64 +: 64] = 64'(idx);
    w_data[p*16 +: 16]  = d;
    w_mask[p*16 +: 16]  = m;
  endtask

  // One clock; the expected counters follow the enables seen at the edge.
  task automatic step();
    int nr, nw;
    nr = $countones(r_enable);
    nw = $countones(w_enable);
    @(posedge clock);
    #1;
    if (!reset) begin
      exp_rd = 0; exp_wr = 0;
    end else begin
      exp_rd += nr; exp_wr += nw;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    step(); step();
    for (int g = 0; g < 4; g++) begin
      checks++; if (r_valid_o[g] !== 2'b00) begin failures++; $display("FAIL reset_valid lat%0d got=%b exp=00", g, r_valid_o[g]); end
      if (g != 0) begin
        checks++; if (r_data_o[g] !== 32'h0) begin failures++; $display("FAIL reset_data lat%0d got=%h exp=0", g, r_data_o[g]); end
      end
      checks++; if (err_oob_o[g] !== 1'b0) begin failures++; $display("FAIL reset_oob lat%0d got=%b exp=0", g, err_oob_o[g]); end
      checks++; if (rd_count_o[g] !== 32'h0 || wr_count_o[g] !== 32'h0) begin failures++; $display("FAIL reset_cnt lat%0d got=%0d/%0d exp=0/0", g, rd_count_o[g], wr_count_o[g]); end
      checks++; if (r_async_o[g] !== 1'(g == 0)) begin failures++; $display("FAIL r_async lat%0d got=%b exp=%b", g, r_async_o[g], g == 0); end
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    idle(); set_wr(0, 5, 16'h1234, 16'hFFFF); step();
    idle(); set_rd(0, 5); #1;
    checks++; if (r_valid_o[0][0] !== 1'b1 || r_data_o[0][15:0] !== 16'h1234) begin failures++; $display("FAIL wr_rd_lat0 got=%b/%h exp=1/1234", r_valid_o[0][0], r_data_o[0][15:0]); end
    step();
    checks++; if (r_valid_o[1][0] !== 1'b1 || r_data_o[1][15:0] !== 16'h1234) begin failures++; $display("FAIL wr_rd_lat1 got=%b/%h exp=1/1234", r_valid_o[1][0], r_data_o[1][15:0]); end
    checks++; if (r_valid_o[2][0] !== 1'b0) begin failures++; $display("FAIL wr_rd_lat2_early got=%b exp=0", r_valid_o[2][0]); end
    idle(); step();
    checks++; if (r_valid_o[1][0] !== 1'b0 || r_data_o[1][15:0] !== 16'h1234) begin failures++; $display("FAIL wr_rd_lat1_hold got=%b/%h exp=0/1234", r_valid_o[1][0], r_data_o[1][15:0]); end
    checks++; if (r_valid_o[2][0] !== 1'b1 || r_data_o[2][15:0] !== 16'h1234) begin failures++; $display("FAIL wr_rd_lat2 got=%b/%h exp=1/1234", r_valid_o[2][0], r_data_o[2][15:0]); end
    step();
    checks++; if (r_valid_o[3][0] !== 1'b1 || r_data_o[3][15:0] !== 16'h1234) begin failures++; $display("FAIL wr_rd_lat3 got=%b/%h exp=1/1234", r_valid_o[3][0], r_data_o[3][15:0]); end
    checks++; if (rd_count_o[1] !== 32'(exp_rd) || wr_count_o[1] !== 32'(exp_wr)) begin failures++; $display("FAIL wr_rd_cnt got=%0d/%0d exp=%0d/%0d", rd_count_o[1], wr_count_o[1], exp_rd, exp_wr); end
  endtask

  task automatic test_conflict();
    idle(); set_wr(0, 3, 16'h0000, 16'hFFFF); set_wr(1, 10, 16'hAAAA, 16'hFFFF); step();
    idle(); set_wr(0, 3, 16'hFFFF, 16'h00FF); set_wr(1, 3, 16'h0000, 16'h0F0F); step();
    idle(); set_wr(0, 10, 16'hFFFF, 16'h0000); set_wr(1, 11, 16'h5555, 16'hFFFF); step();
    idle(); set_rd(0, 3); set_rd(1, 10); step();
    checks++; if (r_data_o[1][15:0] !== 16'h00F0) begin failures++; $display("FAIL conflict_merge got=%h exp=00f0", r_data_o[1][15:0]); end
    checks++; if (r_data_o[1][31:16] !== 16'hAAAA) begin failures++; $display("FAIL mask_zero got=%h exp=aaaa", r_data_o[1][31:16]); end
    checks++; if (r_valid_o[1] !== 2'b11) begin failures++; $display("FAIL dual_rd_valid got=%b exp=11", r_valid_o[1]); end
    idle(); set_rd(1, 11); step();
    checks++; if (r_data_o[1] !== {16'h5555, 16'h00F0} || r_valid_o[1] !== 2'b10) begin failures++; $display("FAIL port1_rd got=%h/%b exp=555500f0/10", r_data_o[1], r_valid_o[1]); end
  endtask

  task automatic test_rdw();
    idle(); set_wr(0, 7, 16'h000A, 16'hFFFF); step();
    idle(); set_wr(1, 7, 16'h000B, 16'hFFFF); set_rd(1, 7); #1;
    checks++; if (r_data_o[0][31:16] !== 16'h000A) begin failures++; $display("FAIL rdw_lat0 got=%h exp=000a", r_data_o[0][31:16]); end
    step();
    checks++; if (r_data_o[1][31:16] !== 16'h000A) begin failures++; $display("FAIL rdw_lat1 got=%h exp=000a", r_data_o[1][31:16]); end
    idle(); step();
    checks++; if (r_valid_o[2][1] !== 1'b1 || r_data_o[2][31:16] !== 16'h000A) begin failures++; $display("FAIL rdw_lat2_old got=%b/%h exp=1/000a", r_valid_o[2][1], r_data_o[2][31:16]); end
    set_rd(1, 7); step();
    idle(); step();
    checks++; if (r_valid_o[2][1] !== 1'b1 || r_data_o[2][31:16] !== 16'h000B) begin failures++; $display("FAIL rdw_lat2_new got=%b/%h exp=1/000b", r_valid_o[2][1], r_data_o[2][31:16]); end
  endtask

  task automatic test_back_to_back();
    idle(); set_rd(0, 5); step();
    idle(); set_rd(0, 3); step();
    checks++; if (r_valid_o[2][0] !== 1'b1 || r_data_o[2][15:0] !== 16'h1234) begin failures++; $display("FAIL b2b_0 got=%b/%h exp=1/1234", r_valid_o[2][0], r_data_o[2][15:0]); end
    checks++; if (r_data_o[1][15:0] !== 16'h00F0) begin failures++; $display("FAIL b2b_lat1 got=%h exp=00f0", r_data_o[1][15:0]); end
    idle(); set_rd(0, 7); step();
    checks++; if (r_valid_o[2][0] !== 1'b1 || r_data_o[2][15:0] !== 16'h00F0) begin failures++; $display("FAIL b2b_1 got=%b/%h exp=1/00f0", r_valid_o[2][0], r_data_o[2][15:0]); end
    idle(); step();
    checks++; if (r_valid_o[2][0] !== 1'b1 || r_data_o[2][15:0] !== 16'h000B) begin failures++; $display("FAIL b2b_2 got=%b/%h exp=1/000b", r_valid_o[2][0], r_data_o[2][15:0]); end
    step();
    checks++; if (r_valid_o[2][0] !== 1'b0 || r_data_o[2][15:0] !== 16'h000B) begin failures++; $display("FAIL b2b_hold got=%b/%h exp=0/000b", r_valid_o[2][0], r_data_o[2][15:0]); end
  endtask

  task automatic test_oob();
    idle(); set_wr(0, 0, 16'h2222, 16'hFFFF); set_wr(1, 63, 16'h6363, 16'hFFFF); step();
    checks++; if (err_oob_o[1] !== 1'b0) begin failures++; $display("FAIL oob_edge63 got=%b exp=0", err_oob_o[1]); end
    idle(); set_wr(0, 64, 16'h1111, 16'hFFFF); step();
    checks++; if (err_oob_o[1] !== 1'b1) begin failures++; $display("FAIL oob_wr_flag got=%b exp=1", err_oob_o[1]); end
    idle(); set_rd(0, 0); set_rd(1, 100); step();
    checks++; if (r_data_o[1] !== {16'h0000, 16'h2222} || r_valid_o[1] !== 2'b11) begin failures++; $display("FAIL oob_rd got=%h/%b exp=00002222/11", r_data_o[1], r_valid_o[1]); end
    idle(); set_rd(1, 63); step();
    checks++; if (r_data_o[1][31:16] !== 16'h6363) begin failures++; $display("FAIL rd_idx63 got=%h exp=6363", r_data_o[1][31:16]); end
    checks++; if (rd_count_o[3] !== 32'(exp_rd) || wr_count_o[3] !== 32'(exp_wr)) begin failures++; $display("FAIL oob_cnt got=%0d/%0d exp=%0d/%0d", rd_count_o[3], wr_count_o[3], exp_rd, exp_wr); end
  endtask

  task automatic test_reset_midflight();
    idle(); set_rd(0, 5); step();
    idle(); set_rd(0, 3); set_rd(1, 7); step();
    reset = 1'b0; idle(); #1;
    checks++; if (r_valid_o[3] !== 2'b00 || rd_count_o[3] !== 32'h0 || wr_count_o[3] !== 32'h0) begin failures++; $display("FAIL midflight_async got=%b/%0d/%0d exp=00/0/0", r_valid_o[3], rd_count_o[3], wr_count_o[3]); end
    step(); step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (r_valid_o[3] !== 2'b00) begin failures++; $display("FAIL midflight_valid c%0d got=%b exp=00", c, r_valid_o[3]); end
    end
    checks++; if (rd_count_o[3] !== 32'h0 || wr_count_o[3] !== 32'h0 || err_oob_o[3] !== 1'b0) begin failures++; $display("FAIL midflight_state got=%0d/%0d/%b exp=0/0/0", rd_count_o[3], wr_count_o[3], err_oob_o[3]); end
  endtask

`ifdef MEM_UNINIT_TRAP_EN
  task automatic test_uninit();
    checks++; if (err_uninit_o[1] !== 1'b0) begin failures++; $display("FAIL uninit_reset got=%b exp=0", err_uninit_o[1]); end
    idle(); set_rd(0, 9); step();
    checks++; if (r_data_o[1][15:0] !== 16'hDEAD || err_uninit_o[1] !== 1'b1) begin failures++; $display("FAIL uninit_poison got=%h/%b exp=dead/1", r_data_o[1][15:0], err_uninit_o[1]); end
    idle(); set_wr(0, 9, 16'h1234, 16'h0000); step();
    idle(); set_rd(0, 9); step();
    checks++; if (r_data_o[1][15:0] !== 16'hDEAD) begin failures++; $display("FAIL uninit_mask0 got=%h exp=dead", r_data_o[1][15:0]); end
    idle(); set_wr(0, 9, 16'h4321, 16'hFFFF); step();
    idle(); set_rd(0, 9); step();
    checks++; if (r_data_o[1][15:0] !== 16'h4321) begin failures++; $display("FAIL uninit_written got=%h exp=4321", r_data_o[1][15:0]); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_conflict();
    test_rdw();
    test_back_to_back();
    test_oob();
    test_reset_midflight();
`ifdef MEM_UNINIT_TRAP_EN
    test_uninit();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
